matrix_module: RTL and testbench

- Parameterised row x column matrix of 8-bit elements, held in registers and presented in full on an unpacked 2-D output port.
- Feeds checkers and consumers that sample the whole matrix at once.
- After reset it holds a fixed, known pattern, so a bench can compare it against a golden vector file.
- A single-cycle command port can write, fill, add to, rotate or restore the contents.

---
 rtl/matrix_module.sv | 158 +++++++++++++++
 tb/tb_matrix_module.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/matrix_module.sv
// rtl/matrix_module.sv - register-held row x column byte matrix with a single-cycle command port
//
// Purpose: holds a row x column matrix of 8-bit elements, loaded with the
// pattern {row[3:0], col[3:0]} on reset, and modified by one command per
// cycle (NOP, WRITE, FILL, RELOAD, ADD, ROTATE). Rejected commands pulse
// cmd_err for one cycle.
//
// Optional feature: define MATRIX_MODULE_SUM_EN to add sum_out, the
// combinational unsigned sum of all elements.
//
// Ports:
//   clk        in   clock, rising-edge active
//   rst        in   asynchronous active-high reset
//   cmd_valid  in   command strobe
//   cmd_op     in   [2:0] opcode
//   cmd_row    in   [3:0] row index operand
//   cmd_col    in   [3:0] column index operand
//   cmd_data   in   [7:0] data operand
//   output_mat out  [7:0] [0:row-1][0:column-1] matrix contents (registered)
//   cmd_err    out  one-cycle pulse after a rejected command
//   sum_out    out  [8+$clog2(row*column)-1:0] element sum (MATRIX_MODULE_SUM_EN only)

module matrix_module #(
    parameter int row    = 4,
    parameter int column = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_row,
    input  logic [3:0] cmd_col,
    input  logic [7:0] cmd_data,
    output logic [7:0] output_mat [0:row-1][0:column-1],
    output logic       cmd_err
`ifdef MATRIX_MODULE_SUM_EN
    ,
    output logic [8+$clog2(row*column)-1:0] sum_out
`endif
);

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_WRITE  = 3'd1;
    localparam logic [2:0] OP_FILL   = 3'd2;
    localparam logic [2:0] OP_RELOAD = 3'd3;
    localparam logic [2:0] OP_ADD    = 3'd4;
    localparam logic [2:0] OP_ROTATE = 3'd5;

    // 5-bit bounds so that row/column = 16 compare correctly against 4-bit indices
    localparam logic [4:0] ROW_N = 5'(row);
    localparam logic [4:0] COL_N = 5'(column);

    logic [7:0] mat_q [0:row-1][0:column-1];
    logic [7:0] mat_d [0:row-1][0:column-1];
    logic       err_q;
    logic       err_d;

    logic row_ok;
    logic col_ok;

    assign row_ok = ({1'b0, cmd_row} < ROW_N);
    assign col_ok = ({1'b0, cmd_col} < COL_N);

    function automatic logic [7:0] dflt(input int r, input int c);
        return {4'(r), 4'(c)};
    endfunction

    always_comb begin
        mat_d = mat_q;
        err_d = 1'b0;
        if (cmd_valid) begin
            case (cmd_op)
                OP_NOP: ;
                OP_WRITE: begin
                    if (row_ok && col_ok) begin
                        for (int r = 0; r < row; r++) begin
                            for (int c = 0; c < column; c++) begin
                                if (cmd_row == 4'(r) && cmd_col == 4'(c)) begin
                                    mat_d[r][c] = cmd_data;
                                end
                            end
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_FILL: begin
                    for (int r = 0; r < row; r++) begin
                        for (int c = 0; c < column; c++) begin
                            mat_d[r][c] = cmd_data;
                        end
                    end
                end
                OP_RELOAD: begin
                    for (int r = 0; r < row; r++) begin
                        for (int c = 0; c < column; c++) begin
                            mat_d[r][c] = dflt(r, c);
                        end
                    end
                end
                OP_ADD: begin
                    // 8-bit add wraps modulo 256 by construction
                    for (int r = 0; r < row; r++) begin
                        for (int c = 0; c < column; c++) begin
                            mat_d[r][c] = mat_q[r][c] + cmd_data;
                        end
                    end
                end
                OP_ROTATE: begin
                    if (row_ok) begin
                        // left rotate; with column = 1 each element maps to itself
                        for (int r = 0; r < row; r++) begin
                            for (int c = 0; c < column; c++) begin
                                if (cmd_row == 4'(r)) begin
                                    mat_d[r][c] = mat_q[r][(c + 1) % column];
                                end
                            end
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < row; r++) begin
                for (int c = 0; c < column; c++) begin
                    mat_q[r][c] <= dflt(r, c);
                end
            end
            err_q <= 1'b0;
        end else begin
            mat_q <= mat_d;
            err_q <= err_d;
        end
    end

    assign output_mat = mat_q;
    assign cmd_err    = err_q;

`ifdef MATRIX_MODULE_SUM_EN
    localparam int SUM_W = 8 + $clog2(row * column);

    always_comb begin
        sum_out = '0;
        for (int r = 0; r < row; r++) begin
            for (int c = 0; c < column; c++) begin
                sum_out = sum_out + SUM_W'(mat_q[r][c]);
            end
        end
    end
`endif

endmodule

// File: tb/tb_matrix_module.sv
// tb/tb_matrix_module.sv - scoreboard testbench for matrix_module (4x4)

module tb_matrix_module;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [2:0] cmd_op;
    logic [3:0] cmd_row;
    logic [3:0] cmd_col;
    logic [7:0] cmd_data;
    logic [7:0] output_mat [0:3][0:3];
    logic       cmd_err;
`ifdef MATRIX_MODULE_SUM_EN
    logic [11:0] sum_out;
`endif

    int errors = 0;
    int checks = 0;

    logic [128:0] exp_q [$];
    string        name_q [$];

    matrix_module #(.row(4), .column(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_row    (cmd_row),
        .cmd_col    (cmd_col),
        .cmd_data   (cmd_data),
        .output_mat (output_mat),
        .cmd_err    (cmd_err)
`ifdef MATRIX_MODULE_SUM_EN
        ,
        .sum_out    (sum_out)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] pat_default();
        logic [127:0] m;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[(r*4+c)*8 +: 8] = {4'(r), 4'(c)};
        return m;
    endfunction

    function automatic logic [127:0] pat_fill(input logic [7:0] v);
        logic [127:0] m;
        for (int k = 0; k < 16; k++) m[k*8 +: 8] = v;
        return m;
    endfunction

    function automatic logic [127:0] set_el(input logic [127:0] m, input int r, input int c,
                                            input logic [7:0] v);
        logic [127:0] t;
        t = m;
        t[(r*4+c)*8 +: 8] = v;
        return t;
    endfunction

    task automatic check(input string nm, input logic [127:0] em, input logic ee);
        logic [127:0] act;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                act[(r*4+c)*8 +: 8] = output_mat[r][c];
        checks++;
        if (act !== em) begin
            errors++;
            $display("FAIL %s matrix: got %h expected %h", nm, act, em);
        end
        checks++;
        if (cmd_err !== ee) begin
            errors++;
            $display("FAIL %s cmd_err: got %b expected %b", nm, cmd_err, ee);
        end
`ifdef MATRIX_MODULE_SUM_EN
        begin
            logic [11:0] es;
            es = '0;
            for (int k = 0; k < 16; k++) es = es + 12'(em[k*8 +: 8]);
            checks++;
            if (sum_out !== es) begin
                errors++;
                $display("FAIL %s sum_out: got %h expected %h", nm, sum_out, es);
            end
        end
`endif
    endtask

    // Drive one cycle of stimulus and queue the result expected after the next rising edge.
    task automatic step(input logic v, input logic [2:0] op, input logic [3:0] r,
                        input logic [3:0] c, input logic [7:0] d,
                        input logic [127:0] em, input logic ee, input string nm);
        @(negedge clk);
        cmd_valid = v;
        cmd_op    = op;
        cmd_row   = r;
        cmd_col   = c;
        cmd_data  = d;
        exp_q.push_back({ee, em});
        name_q.push_back(nm);
    endtask

    // Monitor: every rising edge consumes the expectation queued for it.
    initial begin
        logic [128:0] e;
        string        nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check(nm, e[127:0], e[128]);
            end
        end
    end

    initial begin
        logic [127:0] d0;
        logic [127:0] t;
        d0 = pat_default();

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0;
        cmd_row = 4'd0; cmd_col = 4'd0; cmd_data = 8'h00;
        repeat (2) @(posedge clk);
        #2;
        check("reset_held", d0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        step(1'b0, 3'd0, 4'd0, 4'd0, 8'h00, d0, 1'b0, "idle");
        step(1'b1, 3'd0, 4'd0, 4'd0, 8'hFF, d0, 1'b0, "nop");

        step(1'b1, 3'd1, 4'd2, 4'd3, 8'hA5, set_el(d0, 2, 3, 8'hA5), 1'b0, "write_2_3");
        step(1'b1, 3'd1, 4'd3, 4'd3, 8'h3C,
             set_el(set_el(d0, 2, 3, 8'hA5), 3, 3, 8'h3C), 1'b0, "write_3_3");
        step(1'b1, 3'd3, 4'd0, 4'd0, 8'h00, d0, 1'b0, "reload1");

        step(1'b1, 3'd2, 4'd0, 4'd0, 8'h7F, pat_fill(8'h7F), 1'b0, "fill_7f");
        step(1'b1, 3'd4, 4'd0, 4'd0, 8'h90, pat_fill(8'h0F), 1'b0, "add_90_wrap");
        step(1'b1, 3'd3, 4'd0, 4'd0, 8'h00, d0, 1'b0, "reload2");

        t = d0;
        t = set_el(t, 1, 0, 8'h11); t = set_el(t, 1, 1, 8'h12);
        t = set_el(t, 1, 2, 8'h13); t = set_el(t, 1, 3, 8'h10);
        step(1'b1, 3'd5, 4'd1, 4'd0, 8'h00, t, 1'b0, "rotate_row1");
        step(1'b1, 3'd3, 4'd0, 4'd0, 8'h00, d0, 1'b0, "reload3");

        step(1'b1, 3'd1, 4'd4, 4'd0, 8'hFF, d0, 1'b1, "write_row4_rej");
        step(1'b1, 3'd0, 4'd0, 4'd0, 8'h00, d0, 1'b0, "err_one_cycle1");
        step(1'b1, 3'd6, 4'd0, 4'd0, 8'h00, d0, 1'b1, "op6_rej");
        step(1'b1, 3'd0, 4'd0, 4'd0, 8'h00, d0, 1'b0, "err_one_cycle2");
        step(1'b1, 3'd1, 4'd0, 4'd4, 8'hEE, d0, 1'b1, "write_col4_rej");
        step(1'b1, 3'd7, 4'd0, 4'd0, 8'h00, d0, 1'b1, "op7_rej");
        step(1'b1, 3'd5, 4'd9, 4'd0, 8'h00, d0, 1'b1, "rotate_row9_rej");
        step(1'b0, 3'd6, 4'd0, 4'd0, 8'h00, d0, 1'b0, "invalid_op6_ignored");

        // back-to-back ADDs build on each other: default + 2 per element
        step(1'b1, 3'd4, 4'd0, 4'd0, 8'h01, d0, 1'b0, "add1_a");
        for (int k = 0; k < 16; k++) t[k*8 +: 8] = d0[k*8 +: 8] + 8'h01;
        exp_q[exp_q.size()-1] = {1'b0, t};
        step(1'b1, 3'd4, 4'd0, 4'd0, 8'h01, d0, 1'b0, "add1_b");
        for (int k = 0; k < 16; k++) t[k*8 +: 8] = d0[k*8 +: 8] + 8'h02;
        exp_q[exp_q.size()-1] = {1'b0, t};

        step(1'b1, 3'd2, 4'd0, 4'd0, 8'h55, pat_fill(8'h55), 1'b0, "fill_55");
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        #3;
        check("pre_reset_55", pat_fill(8'h55), 1'b0);
        // asynchronous reset between edges, with a command presented meanwhile
        rst = 1'b1; cmd_valid = 1'b1; cmd_op = 3'd2; cmd_data = 8'hAA;
        #1;
        check("async_reset_immediate", d0, 1'b0);
        @(posedge clk);
        #1;
        check("cmd_during_reset_discarded", d0, 1'b0);
        @(negedge clk);
        rst = 1'b0; cmd_valid = 1'b0;
        step(1'b1, 3'd0, 4'd0, 4'd0, 8'h00, d0, 1'b0, "after_reset_nop");
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
